// File: rtl/core_pkg.sv
//------------------------------------------------------------------------------
// Module  : core_pkg
// Brief   : Shared types and sizes for the register-rename stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package core_pkg;

  localparam int ARCH_REGS = 32;
  localparam int PREGS     = 64;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int PAYLOAD_W = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  localparam areg_t XZR_IDX = 5'd31;

  typedef struct packed {
    preg_t                prs1;
    preg_t                prs2;
    preg_t                prd;
    preg_t                old_prd;
    logic                 rd_we;
    logic [PAYLOAD_W-1:0] payload;
  } rename_pkt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    HOLD  = 2'd2
  } rename_state_t;

  // XZR is architecturally constant, so writes to it never allocate.
  function automatic logic eff_write(input logic we, input areg_t rd);
    return we && (rd != XZR_IDX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rename_stage_if.sv
//------------------------------------------------------------------------------
// Module  : rename_stage_if
// Brief   : Decode, free-list, dispatch, commit and flush signals of the rename stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rename_stage_if #(
  parameter int PREG_W    = core_pkg::PREG_W,
  parameter int PAYLOAD_W = core_pkg::PAYLOAD_W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [4:0]           in_rd;
  logic                 in_rd_we;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 alloc_en;
  logic [PREG_W-1:0]    alloc_phys;
  logic                 alloc_valid;

  logic                 free_en;
  logic [PREG_W-1:0]    free_phys;

  logic                 out_valid;
  logic                 out_ready;
  logic [PREG_W-1:0]    out_prs1;
  logic [PREG_W-1:0]    out_prs2;
  logic [PREG_W-1:0]    out_prd;
  logic [PREG_W-1:0]    out_old_prd;
  logic                 out_rd_we;
  logic [PAYLOAD_W-1:0] out_payload;

  logic                 commit_en;
  logic [4:0]           commit_rd;
  logic [PREG_W-1:0]    commit_prd;
  logic [PREG_W-1:0]    commit_old_prd;

  logic                 flush;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_payload,
    input  alloc_phys, alloc_valid, out_ready,
    input  commit_en, commit_rd, commit_prd, commit_old_prd, flush,
    output in_ready, alloc_en, free_en, free_phys,
    output out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_rd_we, out_payload
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_payload,
    output alloc_phys, alloc_valid, out_ready,
    output commit_en, commit_rd, commit_prd, commit_old_prd, flush,
    input  in_ready, alloc_en, free_en, free_phys,
    input  out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_rd_we, out_payload
  );

endinterface

`default_nettype wire

// File: rtl/rename_map_table.sv
//------------------------------------------------------------------------------
// Module  : rename_map_table
// Brief   : Speculative and retirement arch->phys maps with flush restore.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rename_map_table
  import core_pkg::*;
#(
  parameter int ARCH_REGS = core_pkg::ARCH_REGS
) (
  input  wire logic  clk,
  input  wire logic  reset,
  input  wire areg_t i_rs1,
  input  wire areg_t i_rs2,
  input  wire areg_t i_rd,
  output preg_t      o_prs1,
  output preg_t      o_prs2,
  output preg_t      o_old_prd,
  input  wire logic  i_spec_we,
  input  wire areg_t i_spec_rd,
  input  wire preg_t i_spec_prd,
  input  wire logic  i_ret_we,
  input  wire areg_t i_ret_rd,
  input  wire preg_t i_ret_prd,
  input  wire logic  i_restore
);

  preg_t r_spec [ARCH_REGS];
  preg_t r_ret  [ARCH_REGS];
  preg_t w_ret_next [ARCH_REGS];

  assign o_prs1    = (i_rs1 == XZR_IDX) ? preg_t'(XZR_IDX) : r_spec[i_rs1];
  assign o_prs2    = (i_rs2 == XZR_IDX) ? preg_t'(XZR_IDX) : r_spec[i_rs2];
  assign o_old_prd = r_spec[i_rd];

  // Restore source includes a commit retiring in the same cycle as the flush.
  genvar g;
  generate
    for (g = 0; g < ARCH_REGS; g++) begin : g_ret_next
      assign w_ret_next[g] = (i_ret_we && (i_ret_rd == areg_t'(g))) ? i_ret_prd : r_ret[g];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) r_spec[i] <= preg_t'(i);
    end else if (i_restore) begin
      for (int i = 0; i < ARCH_REGS; i++) r_spec[i] <= w_ret_next[i];
    end else if (i_spec_we) begin
      r_spec[i_spec_rd] <= i_spec_prd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) r_ret[i] <= preg_t'(i);
    end else if (i_ret_we) begin
      r_ret[i_ret_rd] <= i_ret_prd;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rename_stage.sv
//------------------------------------------------------------------------------
// Module  : rename_stage
// Brief   : Single-issue rename: source lookup, destination allocation, commit/flush.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rename_stage
  import core_pkg::*;
#(
  parameter int ARCH_REGS = core_pkg::ARCH_REGS,
  parameter int PHYS_REGS = core_pkg::PREGS
) (
  input  wire logic     clk,
  input  wire logic     reset,
  rename_stage_if.slave bus
);

  rename_state_t r_state;
  rename_pkt_t   r_pkt;
  areg_t         r_rd;
  logic          r_resp_due;
  logic          r_late_resp;
  logic          r_rcl_pend;
  preg_t         r_rcl_phys;

  preg_t w_prs1;
  preg_t w_prs2;
  preg_t w_old_prd;
  logic  w_eff_we;
  logic  w_accept;
  logic  w_alloc_ok;
  logic  w_spec_we;
  logic  w_ret_we;

  assign w_eff_we   = eff_write(bus.in_rd_we, bus.in_rd);
  assign w_accept   = (r_state == IDLE) && bus.in_valid && !bus.flush;
  assign w_alloc_ok = (r_state == ALLOC) && r_resp_due && bus.alloc_valid;
  assign w_spec_we  = w_alloc_ok && !bus.flush;
  assign w_ret_we   = bus.commit_en && (bus.commit_rd != XZR_IDX);

  rename_map_table #(
    .ARCH_REGS (ARCH_REGS)
  ) u_map (
    .clk        (clk),
    .reset      (reset),
    .i_rs1      (bus.in_rs1),
    .i_rs2      (bus.in_rs2),
    .i_rd       (bus.in_rd),
    .o_prs1     (w_prs1),
    .o_prs2     (w_prs2),
    .o_old_prd  (w_old_prd),
    .i_spec_we  (w_spec_we),
    .i_spec_rd  (r_rd),
    .i_spec_prd (bus.alloc_phys),
    .i_ret_we   (w_ret_we),
    .i_ret_rd   (bus.commit_rd),
    .i_ret_prd  (bus.commit_prd),
    .i_restore  (bus.flush)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pkt       <= '0;
      r_rd        <= '0;
      r_resp_due  <= 1'b0;
      r_late_resp <= 1'b0;
      r_rcl_pend  <= 1'b0;
      r_rcl_phys  <= '0;
    end else begin
      // A request pulsed in the flush cycle still gets its response one cycle later.
      r_late_resp <= bus.flush && (r_state == ALLOC) && !r_resp_due;
      if (r_rcl_pend && !bus.commit_en) r_rcl_pend <= 1'b0;
      if ((bus.flush && w_alloc_ok) || (r_late_resp && bus.alloc_valid)) begin
        r_rcl_pend <= 1'b1;
        r_rcl_phys <= bus.alloc_phys;
      end

      if (bus.flush) begin
        r_state    <= IDLE;
        r_resp_due <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.in_valid) begin
              r_pkt.prs1    <= w_prs1;
              r_pkt.prs2    <= w_prs2;
              r_pkt.prd     <= '0;
              r_pkt.rd_we   <= w_eff_we;
              r_pkt.payload <= bus.in_payload;
              r_rd          <= bus.in_rd;
              if (w_eff_we) begin
                r_pkt.old_prd <= w_old_prd;
                r_resp_due    <= 1'b1;
                r_state       <= ALLOC;
              end else begin
                r_pkt.old_prd <= '0;
                r_state       <= HOLD;
              end
            end
          end
          ALLOC: begin
            // Alternates request cycle and response cycle until the free list succeeds.
            if (r_resp_due) begin
              r_resp_due <= 1'b0;
              if (bus.alloc_valid) begin
                r_pkt.prd <= bus.alloc_phys;
                r_state   <= HOLD;
              end
            end else begin
              r_resp_due <= 1'b1;
            end
          end
          HOLD: begin
            if (bus.out_ready) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.alloc_en    = (w_accept && w_eff_we) || ((r_state == ALLOC) && !r_resp_due);
  assign bus.out_valid   = (r_state == HOLD);
  assign bus.out_prs1    = r_pkt.prs1;
  assign bus.out_prs2    = r_pkt.prs2;
  assign bus.out_prd     = r_pkt.prd;
  assign bus.out_old_prd = r_pkt.old_prd;
  assign bus.out_rd_we   = r_pkt.rd_we;
  assign bus.out_payload = r_pkt.payload;

  // Commit owns the free port; a reclaim waits for the first commit-free cycle.
  assign bus.free_en   = bus.commit_en || r_rcl_pend;
  assign bus.free_phys = bus.commit_en ? bus.commit_old_prd :
                         (r_rcl_pend ? r_rcl_phys : '0);

  a_no_xzr_commit: assert property (@(posedge clk) disable iff (reset)
    !(bus.commit_en && (bus.commit_rd == XZR_IDX)));

  a_alloc_range: assert property (@(posedge clk) disable iff (reset)
    w_alloc_ok |-> (int'(bus.alloc_phys) < PHYS_REGS));

endmodule

`default_nettype wire

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Single-issue register-rename stage between decode and dispatch.
- Maps architectural sources to physical registers and requests a new destination register from the free list.
- Holds speculative and retirement map tables.
- Returns superseded physical registers to the free list at commit; on flush, restores the speculative map from the retirement map.

Parameters:
- ARCH_REGS, 32, architectural registers; X31 is XZR and is never renamed.
- PHYS_REGS, core_pkg::PREGS (64), physical registers.
- PREG_W, 6, physical register index width.
- PAYLOAD_W, 32, opaque decode payload carried through the stage.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  stage can accept
- in_rs1, in_rs2, in_rd  in  5 each  architectural register indices
- in_rd_we  in  1  instruction writes rd
- in_payload  in  PAYLOAD_W  carried through unchanged
- alloc_en  out  1  free-list allocate request, one-cycle pulse
- alloc_phys  in  PREG_W  free-list result, sampled the cycle after alloc_en
- alloc_valid  in  1  allocation succeeded, sampled with alloc_phys
- free_en  out  1  release strobe to free list
- free_phys  out  PREG_W  register being released
- out_valid  out  1  renamed instruction valid
- out_ready  in  1  dispatch accepts
- out_prs1, out_prs2, out_prd, out_old_prd  out  PREG_W each  physical mappings
- out_rd_we  out  1  effective write (in_rd_we and rd!=31)
- out_payload  out  PAYLOAD_W  carried payload
- commit_en  in  1  ROB retires a renaming instruction
- commit_rd  in  5  architectural destination
- commit_prd  in  PREG_W  new mapping
- commit_old_prd  in  PREG_W  superseded mapping
- flush  in  1  discard in-flight work and restore the map

Behaviour:
- Reset:
  - Both maps set to arch i -> phys i.
  - FSM goes to IDLE; all outputs 0; pending-reclaim flag cleared.
  - Integration rule: the free list must hold P0..P31 allocated after reset.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid, capture fields and read prs1/prs2 from the speculative map (index 31 reads phys 31).
    - If the effective write is set: read old_prd from map[rd], pulse alloc_en, go to ALLOC.
    - Otherwise: prd=0, old_prd=0, go to HOLD.
  - ALLOC:
    - in_ready=0.
    - alloc_valid=1: prd<=alloc_phys, map[rd]<=alloc_phys, go to HOLD.
    - alloc_valid=0: re-pulse alloc_en next cycle and stay in ALLOC, retrying until success.
  - HOLD:
    - out_valid=1; outputs stay stable until out_ready.
    - On out_ready, go to IDLE.
- Latency: 1 cycle for no-write instructions; 2 cycles minimum with allocation. Peak throughput is one instruction per 2 cycles.
- Source reads always see the previous instruction's mapping: a map write lands no later than the cycle before the next accept.
- Commit:
  - retire_map[commit_rd] <= commit_prd.
  - free_en=1 and free_phys=commit_old_prd, combinational in the same cycle.
  - commit_rd==31 is illegal; assert in simulation.
- Flush (highest priority, any state):
  - Next cycle, speculative map <= retirement map with that same cycle's commit already applied. FSM goes to IDLE, out_valid=0, in_valid ignored.
  - If flush hits ALLOC with a response this cycle and alloc_valid=1, the returned register is reclaimed via the pending-reclaim flag.
  - If flush hits before the response (alloc_en pulsed this cycle), the response is sampled next cycle and reclaimed the same way.
  - A register already written into the speculative map is not reclaimed here; the ROB owns it.
- Free-port arbitration:
  - Commit wins.
  - A pending reclaim drives free_en in the first cycle without commit_en, then clears.
  - At most one reclaim is pending; a second flush cannot occur before the first reclaim is drained.
- Reset mid-operation: immediate return to the reset state; pending reclaim is dropped.

Decomposition:
- core_pkg holds:
  - ARCH_REGS, PREGS, PREG_W, XZR_IDX=31.
  - typedef preg_t.
  - typedef struct rename_pkt_t {prs1, prs2, prd, old_prd, rd_we, payload}.
  - enum rename_state_t {IDLE, ALLOC, HOLD}.
- Sub-module rename_map_table:
  - Speculative and retirement arrays of 32 x preg_t.
  - Two combinational read ports plus old-value read.
  - One speculative write port, one retire write port, and a bulk restore on flush.

Test Plan:
- Reset, then rename rs1=2, rs2=3, rd=4 with alloc response 40 -> out_prs1=2, out_prs2=3, out_prd=40, out_old_prd=4, out_valid in cycle 2.
- Back-to-back: rd=4 (gets 40), then rs1=4, rd=4 (gets 41) -> second out_prs1=40, out_old_prd=40.
- rd=31 with in_rd_we=1 -> no alloc_en, out_rd_we=0, out_valid 1 cycle after accept.
- alloc_valid=0 for 3 responses then 1 with 50 -> alloc_en pulses 4 times, in_ready=0 throughout, out_prd=50.
- Flush the cycle alloc_valid=1 with 45, while commit_en frees 12 -> free_phys=12 that cycle, then 45 next cycle; speculative map equals retirement map.
- out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, then accept resumes.
